// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory stage of the pipeline. It accepts one request per ALU_kick_up pulse
// and handles it in one of three ways:
//   - no memory operation: ALU_result is passed through with one cycle of
//     latency;
//   - misaligned access: no bus request is made, and the stage completes
//     with MEM_result=0 and MEM_misaligned=1;
//   - load or store: the stage drives a simple req/ready data bus, then
//     completes with the load data or with the store address.
// Exactly one MEM_kick_up pulse is produced per accepted request.
// Any ALU_kick_up that arrives while the stage is busy is dropped.
//
// Optional feature (macro MEM_TIMEOUT_EN):
//   Adds an 8-bit watchdog that aborts an access after 255 ACCESS cycles
//   without dmem_ready. An aborted access completes like a misaligned one.
//   When the macro is not defined, ACCESS waits for dmem_ready indefinitely.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   ALU_result[31:0]                 address, or value to pass through
//   ALU_kick_up                      request pulse from the execute stage
//   reg_read_data_2[31:0]            store data
//   Controller_memread/memwrite      load / store select (store wins)
//   Controller_memsize[1:0]          0=byte, 1=half, 2/3=word
//   Controller_memsign               sign-extend loads when 1
//   dmem_req, dmem_we                bus request and write enable
//   dmem_addr[31:0]                  word-aligned bus address
//   dmem_wdata[31:0], dmem_wstrb[3:0] lane-replicated data and byte strobes
//   dmem_ready, dmem_rdata[31:0]     bus completion strobe and read word
//   MEM_kick_up                      one-cycle completion pulse
//   MEM_result[31:0]                 load data, store address or pass-through
//   MEM_busy                         high in ACCESS and DONE
//   MEM_misaligned                   error flag, valid only with MEM_kick_up
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_result,
    input  logic        ALU_kick_up,
    input  logic [31:0] reg_read_data_2,
    input  logic        Controller_memread,
    input  logic        Controller_memwrite,
    input  logic [1:0]  Controller_memsize,
    input  logic        Controller_memsign,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        MEM_kick_up,
    output logic [31:0] MEM_result,
    output logic        MEM_busy,
    output logic        MEM_misaligned
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // The request is latched when it is accepted, so the bus stays stable
    // while the execute stage moves on.
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] result_q;
    logic        mis_q;

    logic        in_mem_op;
    logic        in_misaligned;
    logic [31:0] in_wdata;
    logic [3:0]  in_wstrb;
    logic [31:0] load_data;
    logic        access_abort;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]  timeout_cnt;
`endif

    // Decode of the incoming request: whether it touches memory, whether its
    // alignment is legal for its size, and the data lanes and strobes for a
    // store. Sizes 2 and 3 both mean word, so bit 1 alone selects word.
    always_comb begin
        in_mem_op     = Controller_memread | Controller_memwrite;
        in_misaligned = 1'b0;
        in_wdata      = reg_read_data_2;
        in_wstrb      = 4'b0000;
        case (Controller_memsize)
            2'd0: begin
                in_wdata = {4{reg_read_data_2[7:0]}};
                in_wstrb = 4'b0001 << ALU_result[1:0];
            end
            2'd1: begin
                in_misaligned = ALU_result[0];
                in_wdata      = {2{reg_read_data_2[15:0]}};
                in_wstrb      = ALU_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                in_misaligned = |ALU_result[1:0];
                in_wdata      = reg_read_data_2;
                in_wstrb      = 4'b1111;
            end
        endcase
    end

    // Load data lane selection and extension. This uses the latched address
    // and size, so it is valid for as long as the stage stays in ACCESS.
    always_comb begin
        logic [7:0]  byte_lane;
        logic [15:0] half_lane;
        byte_lane = 8'h00;
        half_lane = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (addr_q[1:0])
            2'd0:    byte_lane = dmem_rdata[7:0];
            2'd1:    byte_lane = dmem_rdata[15:8];
            2'd2:    byte_lane = dmem_rdata[23:16];
            default: byte_lane = dmem_rdata[31:24];
        endcase
        case (size_q)
            2'd0:    load_data = {{24{sign_q & byte_lane[7]}}, byte_lane};
            2'd1:    load_data = {{16{sign_q & half_lane[15]}}, half_lane};
            default: load_data = dmem_rdata;
        endcase
    end

    // The watchdog aborts on the 255th ACCESS cycle when dmem_ready is
    // still low. The counter reads 254 during that cycle because it starts
    // from zero in the first ACCESS cycle.
`ifdef MEM_TIMEOUT_EN
    assign access_abort = (state == ACCESS) && !dmem_ready && (timeout_cnt == 8'd254);
`else
    assign access_abort = 1'b0;
`endif

    // Next-state logic. Only IDLE looks at ALU_kick_up, so a request that
    // arrives while the stage is busy has no effect. A misaligned access
    // skips ACCESS, which keeps its request off the bus.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ALU_kick_up) begin
                    if (!in_mem_op || in_misaligned) begin
                        state_next = DONE;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ready || access_abort) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register. The reset is asynchronous, so asserting it in the
    // middle of an access drops dmem_req right away. A dmem_ready that
    // arrives after reset then finds the stage in IDLE and has no effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch and result capture. MEM_result changes only when a
    // request completes, so it holds its value between completions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= 32'd0;
            size_q   <= 2'd0;
            sign_q   <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            result_q <= 32'd0;
            mis_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ALU_kick_up) begin
                        if (!in_mem_op) begin
                            result_q <= ALU_result;
                            mis_q    <= 1'b0;
                        end else if (in_misaligned) begin
                            result_q <= 32'd0;
                            mis_q    <= 1'b1;
                        end else begin
                            addr_q  <= ALU_result;
                            size_q  <= Controller_memsize;
                            sign_q  <= Controller_memsign;
                            we_q    <= Controller_memwrite;
                            wdata_q <= in_wdata;
                            wstrb_q <= Controller_memwrite ? in_wstrb : 4'b0000;
                            mis_q   <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ready) begin
                        result_q <= we_q ? addr_q : load_data;
                        mis_q    <= 1'b0;
                    end else if (access_abort) begin
                        result_q <= 32'd0;
                        mis_q    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Watchdog counter. It is zeroed on the transition into ACCESS and
    // counts each ACCESS cycle after that.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt <= 8'd0;
        end else if (state != ACCESS && state_next == ACCESS) begin
            timeout_cnt <= 8'd0;
        end else if (state == ACCESS) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
`endif

    assign dmem_req       = (state == ACCESS);
    assign dmem_we        = (state == ACCESS) && we_q;
    assign dmem_addr      = {addr_q[31:2], 2'b00};
    assign dmem_wdata     = wdata_q;
    assign dmem_wstrb     = wstrb_q;
    assign MEM_kick_up    = (state == DONE);
    assign MEM_busy       = (state != IDLE);
    assign MEM_misaligned = (state == DONE) && mis_q;
    assign MEM_result     = result_q;

endmodule
